// File: rtl/h_row_gen_pkg.sv
// Shared constants, shift-table entry type and FSM states for the H-row generator.
package ldpc_pkg;

   localparam int unsigned IDX_W = 14;
   localparam int unsigned NB    = 35;
   localparam logic [IDX_W-1:0] NULL_IDX = 14'h3FFF;

   // Wide enough for the largest legal Z (NB*Z <= 16383 and Z a multiple of 16 gives Z <= 464).
   localparam int unsigned SHIFT_W = 9;

   typedef struct packed {
      logic               valid;
      logic [SHIFT_W-1:0] shift;
   } shift_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EMIT,
      DONE,
      HOLD
   } state_t;

endpackage

// File: rtl/h_row_gen_if.sv
// Burst-request, config and row-output bundle of h_row_gen.
// H_ROW_GEN_CFG_READBACK_EN adds the cfg_re / cfg_rdata readback pair.
interface h_row_gen_if
   import ldpc_pkg::*;
#(
   parameter int unsigned Z  = 256,
   parameter int unsigned MB = 4
);
   localparam int unsigned ZW  = $clog2(Z);
   localparam int unsigned RW  = (MB > 1) ? $clog2(MB) : 1;
   localparam int unsigned CW  = $clog2(NB);
   // One extra bit so that out-of-range start rows can be presented and flagged.
   localparam int unsigned SRW = $clog2(MB * Z) + 1;

   logic                   start;
   logic [SRW-1:0]         start_row;
   logic                   cfg_we;
   logic [RW+CW-1:0]       cfg_addr;
   logic [ZW:0]            cfg_data;
   logic                   en_load;
   logic [NB*IDX_W-1:0]    H_to_sort;
   logic                   busy;
   logic                   done;
   logic                   err;
`ifdef H_ROW_GEN_CFG_READBACK_EN
   logic                   cfg_re;
   logic [ZW:0]            cfg_rdata;

   modport master (
      output start, start_row, cfg_we, cfg_addr, cfg_data, cfg_re,
      input  en_load, H_to_sort, busy, done, err, cfg_rdata
   );
   modport slave (
      input  start, start_row, cfg_we, cfg_addr, cfg_data, cfg_re,
      output en_load, H_to_sort, busy, done, err, cfg_rdata
   );
`else
   modport master (
      output start, start_row, cfg_we, cfg_addr, cfg_data,
      input  en_load, H_to_sort, busy, done, err
   );
   modport slave (
      input  start, start_row, cfg_we, cfg_addr, cfg_data,
      output en_load, H_to_sort, busy, done, err
   );
`endif

endinterface

// File: rtl/h_row_gen_slot_calc.sv
// One output slot: k*Z + ((z + shift) mod Z), or the null index for an unused block.
module h_slot_calc
   import ldpc_pkg::*;
#(
   parameter int unsigned K = 0,
   parameter int unsigned Z = 256
) (
   input  logic [$clog2(Z)-1:0] z,
   input  shift_entry_t         ent,
   output logic [IDX_W-1:0]     idx
);

   logic [31:0] sum;

   // z and shift are both below Z, so a single conditional subtract completes the mod.
   always_comb begin
      sum = 32'(z) + 32'(ent.shift);
      if (sum >= Z) sum = sum - Z;
      idx = ent.valid ? IDX_W'(K * Z + sum) : NULL_IDX;
   end

endmodule

// File: rtl/h_row_gen.sv
// QC-LDPC row expander: a start request emits 16 consecutive parity-check rows for the sorter.
// Optional H_ROW_GEN_CFG_READBACK_EN adds a registered shift-table read port.
module h_row_gen
   import ldpc_pkg::*;
#(
   parameter int unsigned Z   = 256,
   parameter int unsigned MB  = 4,
   parameter int unsigned GAP = 2
) (
   input logic        clk,
   input logic        rst,
   h_row_gen_if.slave bus
);

   localparam int unsigned ZW = $clog2(Z);
   localparam int unsigned RW = (MB > 1) ? $clog2(MB) : 1;
   localparam int unsigned CW = $clog2(NB);
   localparam int unsigned GW = $clog2(GAP + 1);
   localparam logic [ZW-1:0] Z0_MASK = ~ZW'(15);

   state_t              state;
   shift_entry_t        tbl    [MB][NB];
   shift_entry_t        shadow [NB];
   logic [RW-1:0]       b, b_calc;
   logic [ZW-1:0]       z0, z0_calc, z_cur;
   logic [3:0]          r;
   logic [GW-1:0]       hold_cnt;
   logic [NB*IDX_W-1:0] row_next, row_q;
   logic                en_load_q, busy_q, done_q, err_q;
   logic [RW-1:0]       addr_row;
   logic [CW-1:0]       addr_col;
   logic                addr_ok;

   assign addr_row = bus.cfg_addr[RW+CW-1:CW];
   assign addr_col = bus.cfg_addr[CW-1:0];
   assign addr_ok  = (32'(addr_row) < MB) && (32'(addr_col) < NB);

   always_ff @(posedge clk) begin
      if (rst) begin
         tbl <= '{default: '0};
      end else if (bus.cfg_we && addr_ok) begin
         tbl[addr_row][addr_col] <= {bus.cfg_data[ZW], SHIFT_W'(bus.cfg_data[ZW-1:0])};
      end
   end

   // Base row by comparison against multiples of Z, so Z need not be a power of two.
   always_comb begin
      b_calc = '0;
      for (int unsigned i = 1; i < MB; i++) begin
         if (32'(bus.start_row) >= i * Z) b_calc = RW'(i);
      end
      z0_calc = ZW'(32'(bus.start_row) - 32'(b_calc) * Z) & Z0_MASK;
   end

   assign z_cur = z0 | ZW'(r);

   // FETCH reads the live table for row 0 while the shadow is captured; later rows use the shadow.
   for (genvar k = 0; k < NB; k++) begin : g_slot
      h_slot_calc #(
         .K (k),
         .Z (Z)
      ) u_slot (
         .z   (z_cur),
         .ent ((state == FETCH) ? tbl[b][k] : shadow[k]),
         .idx (row_next[k*IDX_W +: IDX_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         en_load_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         row_q     <= '0;
         b         <= '0;
         z0        <= '0;
         r         <= '0;
         hold_cnt  <= '0;
         shadow    <= '{default: '0};
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (32'(bus.start_row) < MB * Z) begin
                     b      <= b_calc;
                     z0     <= z0_calc;
                     r      <= '0;
                     busy_q <= 1'b1;
                     state  <= FETCH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               shadow    <= tbl[b];
               row_q     <= row_next;
               en_load_q <= 1'b1;
               r         <= 4'd1;
               state     <= EMIT;
            end
            EMIT: begin
               row_q <= row_next;
               r     <= r + 4'd1;
               if (r == 4'd15) state <= DONE;
            end
            DONE: begin
               en_load_q <= 1'b0;
               done_q    <= 1'b1;
               hold_cnt  <= '0;
               state     <= HOLD;
            end
            HOLD: begin
               if (hold_cnt == GW'(GAP)) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.en_load   = en_load_q;
   assign bus.H_to_sort = row_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

`ifdef H_ROW_GEN_CFG_READBACK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.cfg_rdata <= '0;
      end else if (bus.cfg_re) begin
         bus.cfg_rdata <= addr_ok ? {tbl[addr_row][addr_col].valid, ZW'(tbl[addr_row][addr_col].shift)} : '0;
      end
   end
`endif

endmodule
